// File: rtl/mdio_phy_slave.sv
// Clause 22 MDIO management slave clocked by MDC; decodes frames to one PHY address.
// Optional MDIO_PREAMBLE_SUPPRESS_EN: after a good frame, accept the next one after a 1-bit preamble.
module mdio_phy_slave #(
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter logic [4:0]  DEF_PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdi,
  output logic        mdo,
  output logic        mdo_en,
  input  logic [4:0]  phy_addr,
  input  logic        phy_addr_ovr,
  output logic [4:0]  reg_addr,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr_en,
  output logic [15:0] reg_wdata,
  output logic        frame_err
);

  localparam logic [3:0] S_PRE   = 4'd0;
  localparam logic [3:0] S_ST    = 4'd1;
  localparam logic [3:0] S_OP    = 4'd2;
  localparam logic [3:0] S_PHYAD = 4'd3;
  localparam logic [3:0] S_REGAD = 4'd4;
  localparam logic [3:0] S_TA    = 4'd5;
  localparam logic [3:0] S_WDATA = 4'd6;
  localparam logic [3:0] S_RDATA = 4'd7;
  localparam logic [3:0] S_SKIP  = 4'd8;

  localparam logic [5:0] PRE_LEN = 6'(PREAMBLE_LEN);

  logic [3:0]  state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  phy_q, phy_d;
  logic        ta_q, ta_d;
  logic [14:0] wsh_q, wsh_d;
  logic [15:0] rsh_q, rsh_d;
  logic        mdo_q, mdo_d;
  logic        mdo_en_q, mdo_en_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic        reg_rd_en_q, reg_rd_en_d;
  logic        reg_wr_en_q, reg_wr_en_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic        frame_err_q, frame_err_d;

  logic [4:0]  sel_addr;
  logic [4:0]  phy_full;
  logic        is_read;
  logic [5:0]  pre_need;

  assign sel_addr = phy_addr_ovr ? phy_addr : DEF_PHY_ADDR;
  assign phy_full = {phy_q, mdi};
  assign is_read  = (op_q == 2'b10);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic sup_q;
  logic frame_ok;
  logic addr_miss;

  assign frame_ok  = ((state_q == S_WDATA) && (bit_cnt_q == 5'd15)) ||
                     ((state_q == S_RDATA) && (bit_cnt_q == 5'd0));
  assign addr_miss = (state_q == S_PHYAD) && (bit_cnt_q == 5'd4) && (phy_full != sel_addr);
  assign pre_need  = sup_q ? 6'd1 : PRE_LEN;

  // Any error or foreign frame re-arms the full preamble requirement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sup_q <= 1'b0;
    end else if (frame_err_d || addr_miss) begin
      sup_q <= 1'b0;
    end else if (frame_ok) begin
      sup_q <= 1'b1;
    end
  end
`else
  assign pre_need = PRE_LEN;
`endif

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    op_d        = op_q;
    phy_d       = phy_q;
    ta_d        = ta_q;
    wsh_d       = wsh_q;
    rsh_d       = rsh_q;
    mdo_d       = mdo_q;
    mdo_en_d    = mdo_en_q;
    reg_addr_d  = reg_addr_q;
    reg_rd_en_d = 1'b0;
    reg_wr_en_d = 1'b0;
    reg_wdata_d = reg_wdata_q;
    frame_err_d = 1'b0;

    case (state_q)
      S_PRE: begin
        if (mdi) begin
          if (pre_cnt_q < PRE_LEN) pre_cnt_d = pre_cnt_q + 6'd1;
        end else if (pre_cnt_q >= pre_need) begin
          // This 0 is the first start bit.
          state_d   = S_ST;
          pre_cnt_d = 6'd0;
        end else begin
          pre_cnt_d = 6'd0;
        end
      end

      S_ST: begin
        if (mdi) begin
          state_d   = S_OP;
          bit_cnt_d = 5'd0;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_PRE;
          pre_cnt_d   = 6'd0;
        end
      end

      S_OP: begin
        op_d = {op_q[0], mdi};
        if (bit_cnt_q == 5'd1) begin
          if ((op_d == 2'b10) || (op_d == 2'b01)) begin
            state_d   = S_PHYAD;
            bit_cnt_d = 5'd0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_SKIP;
            bit_cnt_d   = 5'd27;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end

      S_PHYAD: begin
        phy_d = {phy_q[2:0], mdi};
        if (bit_cnt_q == 5'd4) begin
          if (phy_full == sel_addr) begin
            state_d   = S_REGAD;
            bit_cnt_d = 5'd0;
          end else begin
            state_d   = S_SKIP;
            bit_cnt_d = 5'd22;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end

      S_REGAD: begin
        reg_addr_d = {reg_addr_q[3:0], mdi};
        if (bit_cnt_q == 5'd4) begin
          reg_rd_en_d = is_read;
          state_d     = S_TA;
          bit_cnt_d   = 5'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end

      S_TA: begin
        if (is_read) begin
          // Bank answers one cycle after the strobe; the slave owns the line from here.
          if (bit_cnt_q == 5'd0) begin
            rsh_d     = reg_rdata;
            mdo_en_d  = 1'b1;
            mdo_d     = 1'b0;
            bit_cnt_d = 5'd1;
          end else begin
            mdo_d     = rsh_q[15];
            rsh_d     = {rsh_q[14:0], 1'b0};
            state_d   = S_RDATA;
            bit_cnt_d = 5'd15;
          end
        end else begin
          if (bit_cnt_q == 5'd0) begin
            ta_d      = mdi;
            bit_cnt_d = 5'd1;
          end else if ({ta_q, mdi} == 2'b10) begin
            state_d   = S_WDATA;
            bit_cnt_d = 5'd0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_SKIP;
            bit_cnt_d   = 5'd15;
          end
        end
      end

      S_WDATA: begin
        wsh_d = {wsh_q[13:0], mdi};
        if (bit_cnt_q == 5'd15) begin
          reg_wdata_d = {wsh_q, mdi};
          reg_wr_en_d = 1'b1;
          state_d     = S_PRE;
          pre_cnt_d   = 6'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end

      S_RDATA: begin
        if (bit_cnt_q == 5'd0) begin
          mdo_en_d  = 1'b0;
          mdo_d     = 1'b0;
          state_d   = S_PRE;
          pre_cnt_d = 6'd0;
        end else begin
          mdo_d     = rsh_q[15];
          rsh_d     = {rsh_q[14:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 5'd1;
        end
      end

      S_SKIP: begin
        if (bit_cnt_q == 5'd0) begin
          state_d   = S_PRE;
          pre_cnt_d = 6'd0;
        end else begin
          bit_cnt_d = bit_cnt_q - 5'd1;
        end
      end

      default: begin
        state_d   = S_PRE;
        pre_cnt_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_PRE;
      pre_cnt_q   <= 6'd0;
      bit_cnt_q   <= 5'd0;
      op_q        <= 2'b00;
      phy_q       <= 4'd0;
      ta_q        <= 1'b0;
      wsh_q       <= 15'd0;
      rsh_q       <= 16'd0;
      mdo_q       <= 1'b0;
      mdo_en_q    <= 1'b0;
      reg_addr_q  <= 5'd0;
      reg_rd_en_q <= 1'b0;
      reg_wr_en_q <= 1'b0;
      reg_wdata_q <= 16'd0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      op_q        <= op_d;
      phy_q       <= phy_d;
      ta_q        <= ta_d;
      wsh_q       <= wsh_d;
      rsh_q       <= rsh_d;
      mdo_q       <= mdo_d;
      mdo_en_q    <= mdo_en_d;
      reg_addr_q  <= reg_addr_d;
      reg_rd_en_q <= reg_rd_en_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_wdata_q <= reg_wdata_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign mdo       = mdo_q;
  assign mdo_en    = mdo_en_q;
  assign reg_addr  = reg_addr_q;
  assign reg_rd_en = reg_rd_en_q;
  assign reg_wr_en = reg_wr_en_q;
  assign reg_wdata = reg_wdata_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mdio_phy_slave.sv
// Directed bench for mdio_phy_slave: STA bit-bangs frames, a monitor pops a scoreboard of expected accesses.
module tb_mdio_phy_slave;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_WR   = 2'd1;
  localparam logic [1:0] K_RD   = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [15:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mdi;
  logic        mdo;
  logic        mdo_en;
  logic [4:0]  phy_addr;
  logic        phy_addr_ovr;
  logic [4:0]  reg_addr;
  logic        reg_rd_en;
  logic [15:0] reg_rdata;
  logic        reg_wr_en;
  logic [15:0] reg_wdata;
  logic        frame_err;

  logic [15:0] bank [32];
  txn_t        exp_q [$];

  int checks = 0;
  int errors = 0;
  int mon_wr = 0;
  int mon_rd = 0;
  int mon_err = 0;
  int mon_en = 0;

  logic [16:0] burst;
  int          burst_len = 0;
  logic        pend_valid = 1'b0;
  logic [15:0] pend_data;

  mdio_phy_slave dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mdi          (mdi),
    .mdo          (mdo),
    .mdo_en       (mdo_en),
    .phy_addr     (phy_addr),
    .phy_addr_ovr (phy_addr_ovr),
    .reg_addr     (reg_addr),
    .reg_rd_en    (reg_rd_en),
    .reg_rdata    (reg_rdata),
    .reg_wr_en    (reg_wr_en),
    .reg_wdata    (reg_wdata),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  assign reg_rdata = bank[reg_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_exp(input logic [1:0] kind, output txn_t t);
    check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) t = exp_q.pop_front();
    else t = '{K_NONE, 5'd0, 16'd0};
    check("txn_kind", 32'(t.kind), 32'(kind));
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    txn_t t;
    #1;
    if (!rst_n) begin
      burst_len  = 0;
      pend_valid = 1'b0;
    end else begin
      if (reg_wr_en) begin
        mon_wr++;
        $display("[%0t] write addr=%0h data=%h", $time, reg_addr, reg_wdata);
        pop_exp(K_WR, t);
        check("wr_addr", 32'(reg_addr), 32'(t.addr));
        check("wr_data", 32'(reg_wdata), 32'(t.data));
      end
      if (reg_rd_en) begin
        mon_rd++;
        $display("[%0t] read strobe addr=%0h", $time, reg_addr);
        pop_exp(K_RD, t);
        check("rd_addr", 32'(reg_addr), 32'(t.addr));
        pend_valid = 1'b1;
        pend_data  = t.data;
      end
      if (frame_err) begin
        mon_err++;
        $display("[%0t] frame error", $time);
        pop_exp(K_ERR, t);
      end
      if (mdo_en) begin
        mon_en++;
        burst = {burst[15:0], mdo};
        burst_len++;
      end else if (burst_len != 0) begin
        $display("[%0t] read data %h len=%0d", $time, burst[15:0], burst_len);
        check("rd_pending", 32'(pend_valid), 32'd1);
        check("rd_len", 32'(burst_len), 32'd17);
        check("rd_turn_bit", 32'(burst[16]), 32'd0);
        if (pend_valid) check("rd_data", 32'(burst[15:0]), 32'(pend_data));
        burst_len  = 0;
        pend_valid = 1'b0;
      end
    end
  end

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      mdi = v[i];
      @(posedge clk);
    end
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) send_bits(32'h1, 1);
  endtask

  function automatic logic [31:0] wr_frame(input logic [4:0] pa, input logic [4:0] ra,
                                           input logic [15:0] d);
    return {2'b01, 2'b01, pa, ra, 2'b10, d};
  endfunction

  function automatic logic [31:0] rd_frame(input logic [4:0] pa, input logic [4:0] ra);
    return {2'b01, 2'b10, pa, ra, 2'b11, 16'hFFFF};
  endfunction

  task automatic end_test(input string name, input int wr, input int rd, input int er, input int en);
    #3;
    check({name, "_missing"}, 32'(exp_q.size()), 32'd0);
    check({name, "_wr_cnt"}, 32'(mon_wr), 32'(wr));
    check({name, "_rd_cnt"}, 32'(mon_rd), 32'(rd));
    check({name, "_err_cnt"}, 32'(mon_err), 32'(er));
    check({name, "_mdo_en_cycles"}, 32'(mon_en), 32'(en));
    exp_q.delete();
    mon_wr = 0; mon_rd = 0; mon_err = 0; mon_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mdi = 1'b1; phy_addr = 5'h03; phy_addr_ovr = 1'b1;
    for (int i = 0; i < 32; i++) bank[i] = 16'(i * 257);
    bank[2] = 16'h1234; bank[5] = 16'hC0DE; bank[6] = 16'hBEEF; bank[9] = 16'h0F0F;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mdo", 32'(mdo), 32'd0);
    check("rst_mdo_en", 32'(mdo_en), 32'd0);
    check("rst_strobes", 32'({reg_rd_en, reg_wr_en, frame_err}), 32'd0);
    check("rst_addr_data", 32'({reg_addr, reg_wdata}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain write
    exp_q.push_back('{K_WR, 5'h04, 16'hA5C3});
    preamble(32);
    send_bits(wr_frame(5'h03, 5'h04, 16'hA5C3), 32);
    end_test("write", 1, 0, 0, 0);

    // Plain read
    exp_q.push_back('{K_RD, 5'h02, 16'h1234});
    preamble(32);
    send_bits(rd_frame(5'h03, 5'h02), 32);
    end_test("read", 0, 1, 0, 17);

    // Illegal opcode 11
    exp_q.push_back('{K_ERR, 5'h00, 16'h0000});
    preamble(32);
    send_bits({2'b01, 2'b11, 5'h03, 5'h04, 2'b10, 16'h1111}, 32);
    end_test("op11", 0, 0, 1, 0);

    // Bad write turnaround
    exp_q.push_back('{K_ERR, 5'h00, 16'h0000});
    preamble(32);
    send_bits({2'b01, 2'b01, 5'h03, 5'h04, 2'b00, 16'h2222}, 32);
    end_test("ta00", 0, 0, 1, 0);

    // Short preamble ignored, full preamble accepted
    preamble(20);
    send_bits(wr_frame(5'h03, 5'h0A, 16'h5A5A), 32);
    end_test("short_pre", 0, 0, 0, 0);
    exp_q.push_back('{K_WR, 5'h0A, 16'h5A5A});
    preamble(32);
    send_bits(wr_frame(5'h03, 5'h0A, 16'h5A5A), 32);
    end_test("full_pre", 1, 0, 0, 0);

    // Foreign address, then read to us
    preamble(32);
    send_bits(wr_frame(5'h07, 5'h04, 16'h7777), 32);
    exp_q.push_back('{K_RD, 5'h05, 16'hC0DE});
    preamble(32);
    send_bits(rd_frame(5'h03, 5'h05), 32);
    end_test("mismatch", 0, 1, 0, 17);

    // Default address when override is low
    phy_addr_ovr = 1'b0;
    exp_q.push_back('{K_WR, 5'h01, 16'h0F0F});
    preamble(32);
    send_bits(wr_frame(5'h00, 5'h01, 16'h0F0F), 32);
    end_test("def_addr", 1, 0, 0, 0);
    phy_addr_ovr = 1'b1;

    // Reset on the 5th read data bit
    exp_q.push_back('{K_RD, 5'h06, 16'hBEEF});
    preamble(32);
    send_bits(rd_frame(5'h03, 5'h06) >> 12, 20);
    @(negedge clk);
    rst_n = 1'b0;
    mdi = 1'b1;
    @(posedge clk);
    #1;
    check("abort_mdo_en", 32'(mdo_en), 32'd0);
    check("abort_reg_addr", 32'(reg_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_bits(32'h7FF, 11);
    end_test("rst_abort", 0, 1, 0, 6);

    exp_q.push_back('{K_RD, 5'h06, 16'hBEEF});
    preamble(32);
    send_bits(rd_frame(5'h03, 5'h06), 32);
    end_test("post_rst_read", 0, 1, 0, 17);

    // Back-to-back read after a single preamble bit
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    exp_q.push_back('{K_RD, 5'h09, 16'h0F0F});
    preamble(1);
    send_bits(rd_frame(5'h03, 5'h09), 32);
    end_test("one_bit_pre", 0, 1, 0, 17);
`else
    preamble(1);
    send_bits(rd_frame(5'h03, 5'h09), 32);
    end_test("one_bit_pre", 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
